// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first subtractor: one full-subtractor cell per clock,
// WIDTH shift cycles per operation, then a single-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;

  logic ai, bi, d_bit, br_next, last_bit;

  assign ai       = a_q[0];
  assign bi       = b_q[0];
  assign d_bit    = ai ^ bi ^ br_q;
  assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        // final borrow is published together with the last result bit
        if (last_bit) begin
          borrow_d = br_next;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff   = res_q;
  assign borrow = borrow_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus random bench for serial_subtractor (WIDTH=8) against
// a plain-arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fail;
  int cyc;
  int last_done;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .borrow(borrow),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one operation at the next posedge and checks the whole
  // WIDTH+2 cycle window. Returns at a negedge with the block in IDLE.
  task automatic run_op(input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input bit hold);
    logic [W:0] ref_full;
    ref_full = {1'b0, av} - {1'b0, bv};
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= W + 1; i++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      if (!hold) start = (i == 2);
      if (i <= W) begin
        chk("busy", {31'b0, busy}, 32'd1);
        chk("done", {31'b0, done}, {31'b0, (i == W)});
      end else begin
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("done_idle", {31'b0, done}, 32'd0);
      end
      if (i >= W) begin
        chk("diff", {24'b0, diff}, {24'b0, ref_full[W-1:0]});
        chk("borrow", {31'b0, borrow}, {31'b0, ref_full[W]});
      end
      if (i == W) last_done = cyc;
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int prev;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    last_done = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_diff", {24'b0, diff}, 32'd0);
    chk("rst_borrow", {31'b0, borrow}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'h3C, 8'h5A, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0);

    // idle hold of last result
    repeat (3) @(negedge clk);
    chk("hold_diff", {24'b0, diff}, 32'h01);
    chk("hold_borrow", {31'b0, borrow}, 32'd1);

    // reset in the middle of SHIFT
    a     = 8'hA5;
    b     = 8'h12;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_diff", {24'b0, diff}, 32'd0);
    chk("abort_borrow", {31'b0, borrow}, 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_nodone", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h10, 8'h01, 1'b0);

    // start held high: back-to-back every WIDTH+2 cycles
    run_op(8'h81, 8'h7F, 1'b1);
    prev = last_done;
    run_op(8'h33, 8'hC4, 1'b1);
    chk("b2b_gap1", 32'(last_done - prev), 32'(W + 2));
    prev = last_done;
    run_op(8'hE7, 8'h19, 1'b0);
    chk("b2b_gap2", 32'(last_done - prev), 32'(W + 2));
    @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; SHALL be at least 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 Port: b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 Port: diff  output  WIDTH  registered result, a minus b modulo 2^WIDTH.
REQ-008 Port: borrow  output  1  registered final borrow; 1 when a < b (unsigned).
REQ-009 Port: busy  output  1  high while a subtraction is in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking that diff and borrow are valid.

Function
REQ-011 Architecture SHALL be bit-serial, LSB first: one 1-bit full-subtractor cell, one borrow flip-flop, and operand and result shift registers; no WIDTH-bit parallel subtractor.
REQ-012 FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at an edge: the FSM SHALL capture a and b, clear the borrow flip-flop and the bit counter, and move to SHIFT.
REQ-014 IDLE with start=0: the FSM SHALL stay in IDLE.
REQ-015 Each SHIFT cycle SHALL use the current LSBs ai and bi and the borrow flip-flop br to compute d = ai ^ bi ^ br and br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-016 Each SHIFT cycle SHALL shift the operand registers right by one and shift d into the MSB of the result register.
REQ-017 Each SHIFT cycle SHALL increment the bit counter.
REQ-018 SHIFT SHALL last exactly WIDTH cycles, then the FSM SHALL move to DONE.
REQ-019 DONE SHALL last exactly one cycle, then the FSM SHALL move to IDLE.
REQ-020 In DONE, diff SHALL equal the full result register and borrow SHALL equal the final br.
REQ-021 Latency: for start accepted at edge k, done SHALL be 1 only during the cycle after edge k+WIDTH; diff and borrow SHALL be valid from that cycle onward.
REQ-022 diff and borrow SHALL hold their last values in IDLE until the next accepted start.
REQ-023 From the accepted start until that start is at least WIDTH cycles old, diff SHALL show the partially shifted result register and SHALL be treated as invalid.
REQ-024 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-025 start SHALL be ignored in SHIFT and DONE; there is no queuing and the captured operands SHALL NOT change.
REQ-026 Changes on a or b after capture SHALL NOT affect the result.
REQ-027 Back-to-back operation: start held at 1 SHALL be accepted again on the first edge in IDLE, so consecutive operations are WIDTH+2 cycles apart.
REQ-028 Boundaries: a = b SHALL give diff = 0 and borrow = 0; 0 - (2^WIDTH - 1) SHALL give diff = 1 and borrow = 1.

Reset
REQ-029 While rst_n = 0, the FSM SHALL be in IDLE, regardless of clk.
REQ-030 While rst_n = 0, the counter, borrow flip-flop, operand registers, diff, borrow, busy and done SHALL all be 0, regardless of clk.
REQ-031 Reset asserted mid-operation SHALL abort the operation immediately, with no done pulse.
REQ-032 After rst_n rises, the first start SHALL be accepted normally.

Verification (WIDTH=8)
REQ-033 a=0x5A, b=0x3C, start pulse -> after 8 cycles done=1, diff=0x1E, borrow=0; busy high for 9 cycles.
REQ-034 a=0x3C, b=0x5A -> diff=0xE2, borrow=1; a=0x00, b=0x01 -> diff=0xFF, borrow=1.
REQ-035 a=0xFF, b=0xFF -> diff=0x00, borrow=0; a=0x00, b=0xFF -> diff=0x01, borrow=1.
REQ-036 Pulse start again on cycle 3 of SHIFT and change a and b mid-operation -> first result is unchanged and exactly one done pulse occurs.
REQ-037 Drop rst_n low on cycle 4 of SHIFT -> busy=0, done=0 and diff=0 immediately; the next start with 0x10 - 0x01 gives diff=0x0F, borrow=0.
REQ-038 Hold start at 1 for 3 operations -> done pulses occur 10 cycles apart and every result matches a reference model.
